// File: rtl/mmio_dev.sv
// mmio_dev -- memory-mapped I/O window for a small 16-bit core.
//
// Decodes the 0xFFF0..0xFFFF window, serves zero-latency loads, captures
// stores on the clock edge, and conditions the raw board keys and switches
// through a 2-flop synchronizer plus a per-bit debounce counter.
//
// Ports:
//   CLK, RESET_N        clock, asynchronous active-low reset
//   ADDR, WDATA, WE     write-back stage address, store data, store strobe
//   RDATA, SEL          combinational load data, window hit
//   KEY_IN, SW_IN       raw keys (active-low) and switches
//   HEX_VAL, LEDR_VAL,  display / LED register contents
//   LEDG_VAL
//   KEY_IRQ             OR of the sticky key-press bits

// One synchronizer + debounce lane. RST_VAL is the idle level of the input.
module mmio_dev_db #(
   parameter int   DB_CYCLES = 500000,
   parameter int   CNTBITS   = 20,
   parameter logic RST_VAL   = 1'b0
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic din,
   output logic db,
   output logic chg   // debounced value flips on the coming edge
);
   logic [1:0]         sync_q, sync_d;
   logic [CNTBITS-1:0] cnt_q, cnt_d;
   logic               db_q, db_d;

   always_comb begin
      sync_d = {sync_q[0], din};
      cnt_d  = cnt_q;
      db_d   = db_q;
      if (sync_q[1] == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNTBITS'(DB_CYCLES - 1)) begin
         db_d  = sync_q[1];
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_q <= {2{RST_VAL}};
         cnt_q  <= '0;
         db_q   <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         db_q   <= db_d;
      end
   end

   assign db  = db_q;
   assign chg = db_q ^ db_d;
endmodule

module mmio_dev #(
   parameter int DBITS     = 16,
   parameter int DB_CYCLES = 500000,
   parameter int CNTBITS   = 20
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [DBITS-1:0] ADDR,
   input  logic [DBITS-1:0] WDATA,
   input  logic             WE,
   output logic [DBITS-1:0] RDATA,
   output logic             SEL,
   input  logic [3:0]       KEY_IN,
   input  logic [9:0]       SW_IN,
   output logic [15:0]      HEX_VAL,
   output logic [9:0]       LEDR_VAL,
   output logic [7:0]       LEDG_VAL,
   output logic             KEY_IRQ
);
   localparam int NUM_LANES = 14;   // lanes 0..3 keys, 4..13 switches

   logic [NUM_LANES-1:0] raw, db, chg;
   logic [15:0]          hex_q, hex_d;
   logic [9:0]           ledr_q, ledr_d;
   logic [7:0]           ledg_q, ledg_d;
   logic [7:0]           kstat_q, kstat_d;
   logic [3:0]           ev;
   logic [7:0]           clr;
   logic                 wr;
   logic [15:0]          rd;
   logic                 unused_bits;

   assign raw = {SW_IN, KEY_IN};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      mmio_dev_db #(
         .DB_CYCLES(DB_CYCLES),
         .CNTBITS  (CNTBITS),
         .RST_VAL  ((i < 4) ? 1'b1 : 1'b0)
      ) u_db (
         .CLK    (CLK),
         .RESET_N(RESET_N),
         .din    (raw[i]),
         .db     (db[i]),
         .chg    (chg[i])
      );
   end

   assign SEL = (ADDR[15:4] == 12'hFFF);
   assign wr  = WE & SEL;

   // A key lane that changes while currently high is a press (1->0).
   assign ev  = db[3:0] & chg[3:0];
   assign clr = (wr && ADDR[3:1] == 3'd2) ? WDATA[7:0] : 8'h00;

   always_comb begin
      hex_d  = hex_q;
      ledr_d = ledr_q;
      ledg_d = ledg_q;
      // Event beats a simultaneous clear; overrun only when the sticky bit
      // survives into this cycle and is not being cleared.
      kstat_d[3:0] = ev | (kstat_q[3:0] & ~clr[3:0]);
      kstat_d[7:4] = (ev & kstat_q[3:0] & ~clr[3:0]) | (kstat_q[7:4] & ~clr[7:4]);
      if (wr) begin
         case (ADDR[3:1])
            3'd4:    hex_d  = WDATA[15:0];
            3'd5:    ledr_d = WDATA[9:0];
            3'd6:    ledg_d = WDATA[7:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hex_q   <= '0;
         ledr_q  <= '0;
         ledg_q  <= '0;
         kstat_q <= '0;
      end else begin
         hex_q   <= hex_d;
         ledr_q  <= ledr_d;
         ledg_q  <= ledg_d;
         kstat_q <= kstat_d;
      end
   end

   always_comb begin
      rd = 16'hDEAD;
      if (SEL) begin
         case (ADDR[3:1])
            3'd0:    rd = {12'b0, ~db[3:0]};
            3'd1:    rd = {6'b0, db[13:4]};
            3'd2:    rd = {8'b0, kstat_q};
            3'd4:    rd = hex_q;
            3'd5:    rd = {6'b0, ledr_q};
            3'd6:    rd = {8'b0, ledg_q};
            default: rd = 16'hDEAD;
         endcase
      end
   end

   assign RDATA    = DBITS'(rd);
   assign HEX_VAL  = hex_q;
   assign LEDR_VAL = ledr_q;
   assign LEDG_VAL = ledg_q;
   assign KEY_IRQ  = |kstat_q[3:0];

   assign unused_bits = ^{ADDR[0], chg[13:4]};
endmodule

// File: tb/tb_mmio_dev.sv
// tb_mmio_dev -- directed bench for mmio_dev with DB_CYCLES=4.
module tb_mmio_dev;
   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [15:0] ADDR, WDATA, RDATA;
   logic        WE, SEL, KEY_IRQ;
   logic [3:0]  KEY_IN;
   logic [9:0]  SW_IN;
   logic [15:0] HEX_VAL;
   logic [9:0]  LEDR_VAL;
   logic [7:0]  LEDG_VAL;

   int total = 0;
   int bad   = 0;

   mmio_dev #(.DBITS(16), .DB_CYCLES(4), .CNTBITS(3)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .ADDR    (ADDR),
      .WDATA   (WDATA),
      .WE      (WE),
      .RDATA   (RDATA),
      .SEL     (SEL),
      .KEY_IN  (KEY_IN),
      .SW_IN   (SW_IN),
      .HEX_VAL (HEX_VAL),
      .LEDR_VAL(LEDR_VAL),
      .LEDG_VAL(LEDG_VAL),
      .KEY_IRQ (KEY_IRQ)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
      ADDR = a;
      #1;
      check(tag, RDATA, exp);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      ADDR  = a;
      WDATA = d;
      WE    = 1'b1;
      tick();
      WE    = 1'b0;
   endtask

   initial begin
      RESET_N = 1'b0;
      KEY_IN  = 4'hF;
      SW_IN   = 10'h000;
      WE      = 1'b0;
      ADDR    = 16'h0000;
      WDATA   = 16'h0000;

      // Reset state, combinational outputs live during reset
      #12;
      check("rst_hex", HEX_VAL, 16'h0000);
      check("rst_irq", {15'b0, KEY_IRQ}, 16'h0000);
      rd(16'hFFF0, 16'h0000, "rst_keydata");
      check("rst_sel", {15'b0, SEL}, 16'h0001);
      tick();
      RESET_N = 1'b1;
      tick();

      // Post-reset register map reads
      rd(16'hFFF8, 16'h0000, "hex_rst");
      rd(16'hFFFA, 16'h0000, "ledr_rst");
      rd(16'hFFFC, 16'h0000, "ledg_rst");
      rd(16'hFFF4, 16'h0000, "kstat_rst");
      rd(16'hFFF6, 16'hDEAD, "unmapped6");
      rd(16'hFFFE, 16'hDEAD, "unmappedE");
      rd(16'h0010, 16'hDEAD, "outside");
      check("outside_sel", {15'b0, SEL}, 16'h0000);
      check("irq_rst", {15'b0, KEY_IRQ}, 16'h0000);

      // Register writes
      wr(16'hFFF8, 16'hBEEF);
      check("hex_wr", HEX_VAL, 16'hBEEF);
      rd(16'hFFF8, 16'hBEEF, "hex_rd");
      wr(16'hFFFA, 16'h03FF);
      check("ledr_wr", {6'b0, LEDR_VAL}, 16'h03FF);
      rd(16'hFFFA, 16'h03FF, "ledr_rd");
      wr(16'hFFFC, 16'h01A5);
      check("ledg_wr", {8'b0, LEDG_VAL}, 16'h00A5);
      rd(16'hFFFC, 16'h00A5, "ledg_rd");
      wr(16'hFFF0, 16'h1234);
      rd(16'hFFF0, 16'h0000, "keydata_ro");
      wr(16'h0018, 16'h1111);
      check("nosel_wr", HEX_VAL, 16'hBEEF);
      ADDR  = 16'hFFF8;
      WDATA = 16'h2222;
      tick();
      check("we0_wr", HEX_VAL, 16'hBEEF);
      wr(16'hFFF9, 16'h0055);
      check("addr0_ign", HEX_VAL, 16'h0055);

      // Switch debounce: 2 sync + 4 count cycles
      ADDR  = 16'hFFF2;
      SW_IN = 10'h2A5;
      for (int c = 1; c <= 5; c++) begin
         tick();
         check("sw_wait", RDATA, 16'h0000);
      end
      tick();
      check("sw_set", RDATA, 16'h02A5);
      SW_IN = 10'h2A4;
      tick(); tick(); tick();
      SW_IN = 10'h2A5;
      for (int c = 1; c <= 8; c++) begin
         tick();
         check("sw_glitch", RDATA, 16'h02A5);
      end

      // Key 2 press, release, second press -> overrun, then W1C
      ADDR   = 16'hFFF0;
      KEY_IN = 4'b1011;
      for (int c = 1; c <= 5; c++) begin
         tick();
         check("key_wait", RDATA, 16'h0000);
      end
      tick();
      check("key_set", RDATA, 16'h0004);
      rd(16'hFFF4, 16'h0004, "kstat_ev");
      check("irq_ev", {15'b0, KEY_IRQ}, 16'h0001);
      KEY_IN = 4'b1111;
      for (int c = 1; c <= 6; c++) tick();
      rd(16'hFFF0, 16'h0000, "key_rel");
      rd(16'hFFF4, 16'h0004, "kstat_sticky");
      KEY_IN = 4'b1011;
      for (int c = 1; c <= 6; c++) tick();
      rd(16'hFFF4, 16'h0044, "kstat_ovr");
      wr(16'hFFF4, 16'h0044);
      rd(16'hFFF4, 16'h0000, "kstat_clr");
      check("irq_clr", {15'b0, KEY_IRQ}, 16'h0000);

      // Key 0 press event coincides with a W1C of bit 0
      KEY_IN = 4'b1010;
      for (int c = 1; c <= 5; c++) tick();
      rd(16'hFFF4, 16'h0000, "kstat_pre");
      wr(16'hFFF4, 16'h0001);
      rd(16'hFFF4, 16'h0001, "ev_beats_clr");
      check("irq_race", {15'b0, KEY_IRQ}, 16'h0001);
      wr(16'hFFF4, 16'h0001);
      rd(16'hFFF4, 16'h0000, "kstat_clr0");

      // Reset mid-debounce on key 1 (count reaches 2), full latency after
      KEY_IN = 4'b1000;
      for (int c = 1; c <= 4; c++) tick();
      RESET_N = 1'b0;
      #1;
      check("mid_rst_hex", HEX_VAL, 16'h0000);
      rd(16'hFFF0, 16'h0000, "mid_rst_key");
      rd(16'hFFF2, 16'h0000, "mid_rst_sw");
      tick(); tick();
      RESET_N = 1'b1;
      ADDR    = 16'hFFF0;
      for (int c = 1; c <= 5; c++) begin
         tick();
         check("rst_key_wait", RDATA, 16'h0000);
      end
      tick();
      check("rst_key_set", RDATA, 16'h0007);
      rd(16'hFFF2, 16'h02A5, "rst_sw_set");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
